// File: rtl/fpall_issue_collector_if.sv
// rtl/fpall_issue_collector_if.sv - FP format/op types and request/response port bundle for fpall_issue_collector
package fpall_issue_pkg;
    typedef enum logic [1:0] {
        FP32 = 2'd0,
        FP16 = 2'd1
    } fp_fmt_e;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_MIN = 3'd3,
        OP_MAX = 3'd4
    } fp_op_e;
endpackage

interface fpall_issue_collector_if
`ifdef FPALL_ISSUE_TAG_EN
    #(parameter int TAG_W = 4)
`endif
    ;
    import fpall_issue_pkg::*;

    logic        req_valid;
    logic        req_ready;
    fp_fmt_e     req_fmt;
    fp_op_e      req_op;
    logic [31:0] req_x;
    logic [31:0] req_y;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_r;
`ifdef FPALL_ISSUE_TAG_EN
    logic [TAG_W-1:0] req_tag;
    logic [TAG_W-1:0] rsp_tag;
`endif

    modport master (
        output req_valid, req_fmt, req_op, req_x, req_y, rsp_ready,
        input  req_ready, rsp_valid, rsp_r
`ifdef FPALL_ISSUE_TAG_EN
        , output req_tag
        , input  rsp_tag
`endif
    );

    modport slave (
        input  req_valid, req_fmt, req_op, req_x, req_y, rsp_ready,
        output req_ready, rsp_valid, rsp_r
`ifdef FPALL_ISSUE_TAG_EN
        , input  req_tag
        , output rsp_tag
`endif
    );
endinterface

// File: rtl/fpall_issue_collector.sv
// rtl/fpall_issue_collector.sv - credit-based issue front end and in-order response FIFO for a fixed-latency FPU
// Optional tag path enabled by defining FPALL_ISSUE_TAG_EN.
module fpall_issue_collector
    import fpall_issue_pkg::*;
#(
    parameter int LAT   = 2,
    parameter int DEPTH = 4,
    parameter int II    = 1
`ifdef FPALL_ISSUE_TAG_EN
    ,
    parameter int TAG_W = 4
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    fpall_issue_collector_if.slave  bus,
    output fp_fmt_e                 fpu_fmt,
    output fp_op_e                  fpu_op,
    output logic [31:0]             fpu_x,
    output logic [31:0]             fpu_y,
    input  logic [31:0]             fpu_r,
    output logic                    busy
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (II > 1) ? $clog2(II) : 1;

    logic [LAT-1:0] sr_v;
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [IW-1:0]  ii_cnt;
    logic [31:0]    r_mem [DEPTH];
    logic           accept;
    logic           push;
    logic           pop;
    logic           rsp_valid;
    logic           credit_ok;
    int unsigned    occupancy;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Every op in flight already owns a FIFO slot, so results can never be dropped.
    always_comb begin
        occupancy = 32'(count);
        for (int i = 0; i < LAT; i++) begin
            occupancy = occupancy + 32'(sr_v[i]);
        end
    end

    assign credit_ok     = occupancy < 32'(DEPTH);
    assign bus.req_ready = !rst && (ii_cnt == '0) && credit_ok;
    assign accept        = bus.req_valid && bus.req_ready;
    assign push          = sr_v[LAT-1];
    assign rsp_valid     = count != '0;
    assign pop           = rsp_valid && bus.rsp_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_r     = rsp_valid ? r_mem[rd_ptr] : '0;
    assign busy          = (|sr_v) || (count != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            fpu_fmt <= FP32;
            fpu_op  <= OP_ADD;
            fpu_x   <= '0;
            fpu_y   <= '0;
        end else if (accept) begin
            fpu_fmt <= bus.req_fmt;
            fpu_op  <= bus.req_op;
            fpu_x   <= bus.req_x;
            fpu_y   <= bus.req_y;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ii_cnt <= '0;
        end else if (accept) begin
            ii_cnt <= IW'(II - 1);
        end else if (ii_cnt != '0) begin
            ii_cnt <= ii_cnt - IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_v <= '0;
        end else begin
            sr_v[0] <= accept;
            for (int i = 1; i < LAT; i++) begin
                sr_v[i] <= sr_v[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[wr_ptr] <= fpu_r;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && !pop && count == CW'(DEPTH)));
        end
    end

`ifdef FPALL_ISSUE_TAG_EN
    logic [TAG_W-1:0] sr_tag [LAT];
    logic [TAG_W-1:0] t_mem  [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                sr_tag[i] <= '0;
            end
        end else begin
            sr_tag[0] <= bus.req_tag;
            for (int i = 1; i < LAT; i++) begin
                sr_tag[i] <= sr_tag[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            t_mem[wr_ptr] <= sr_tag[LAT-1];
        end
    end

    assign bus.rsp_tag = rsp_valid ? t_mem[rd_ptr] : '0;
`endif

endmodule

// File: tb/tb_fpall_issue_collector.sv
// tb/tb_fpall_issue_collector.sv - directed self-checking bench for fpall_issue_collector
module tb_fpall_issue_collector;
    import fpall_issue_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    fpall_issue_collector_if bus1 ();
    fpall_issue_collector_if bus2 ();

    fp_fmt_e     fmt1, fmt2;
    fp_op_e      op1, op2;
    logic [31:0] x1, y1, r1, x2, y2, r2;
    logic        busy1, busy2;
    logic [31:0] stage1, stage2;

    fpall_issue_collector #(.LAT(2), .DEPTH(4), .II(1)) u1 (
        .clk(clk), .rst(rst), .bus(bus1),
        .fpu_fmt(fmt1), .fpu_op(op1), .fpu_x(x1), .fpu_y(y1), .fpu_r(r1), .busy(busy1)
    );

    fpall_issue_collector #(.LAT(2), .DEPTH(4), .II(2)) u2 (
        .clk(clk), .rst(rst), .bus(bus2),
        .fpu_fmt(fmt2), .fpu_op(op2), .fpu_x(x2), .fpu_y(y2), .fpu_r(r2), .busy(busy2)
    );

    // bf16 integers 0..9
    logic [15:0] bfn [10] = '{16'h0000, 16'h3F80, 16'h4000, 16'h4040, 16'h4080,
                              16'h40A0, 16'h40C0, 16'h40E0, 16'h4100, 16'h4110};

    function automatic real bf_to_real(input logic [15:0] h);
        real v;
        int  e;
        if (h[14:7] == 8'd0) return 0.0;
        v = 1.0 + real'(int'(h[6:0])) / 128.0;
        e = int'(h[14:7]) - 127;
        while (e > 0) begin v = v * 2.0; e--; end
        while (e < 0) begin v = v / 2.0; e++; end
        return v;
    endfunction

    function automatic logic [15:0] real_to_bf(input real v);
        int         e;
        int         m;
        logic [7:0] eb;
        logic [6:0] mb;
        if (v <= 0.0) return 16'h0000;
        e = 127;
        while (v >= 2.0) begin v = v / 2.0; e++; end
        while (v < 1.0) begin v = v * 2.0; e--; end
        m  = int'((v - 1.0) * 128.0);
        eb = e[7:0];
        mb = m[6:0];
        return {1'b0, eb, mb};
    endfunction

    function automatic logic [31:0] fpu_add(input logic [31:0] a, input logic [31:0] b);
        return {real_to_bf(bf_to_real(a[31:16]) + bf_to_real(b[31:16])),
                real_to_bf(bf_to_real(a[15:0])  + bf_to_real(b[15:0]))};
    endfunction

    // Two-cycle FPU: one internal register stage after the issue register.
    always @(posedge clk) begin
        stage1 <= fpu_add(x1, y1);
        stage2 <= fpu_add(x2, y2);
    end
    assign r1 = stage1;
    assign r2 = stage2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int acc, got, j, first_c, last_c, pops;
    logic [3:0] tags [4] = '{4'd3, 4'd0, 4'd7, 4'd1};

    initial begin
        rst = 1'b1;
        bus1.req_valid = 1'b0; bus1.req_fmt = FP32; bus1.req_op = OP_ADD;
        bus1.req_x = '0; bus1.req_y = '0; bus1.rsp_ready = 1'b0;
        bus2.req_valid = 1'b0; bus2.req_fmt = FP16; bus2.req_op = OP_ADD;
        bus2.req_x = '0; bus2.req_y = 32'h3F80_3F80; bus2.rsp_ready = 1'b1;
`ifdef FPALL_ISSUE_TAG_EN
        bus1.req_tag = '0;
        bus2.req_tag = '0;
`endif
        tick();
        tick();
        chk("rst_req_ready", bus1.req_ready, 0);
        chk("rst_rsp_valid", bus1.rsp_valid, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_fpu_x", x1, 0);
        chk("rst_fpu_fmt", fmt1, 0);
        chk("rst_rsp_r", bus1.rsp_r, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", bus1.req_ready, 1);

        // single op latency
        bus1.req_valid = 1'b1; bus1.req_fmt = FP16; bus1.req_op = OP_ADD;
        bus1.req_x = 32'h3F80_4000; bus1.req_y = 32'h3F80_4000;
        #1;
        chk("t1_ready", bus1.req_ready, 1);
        tick();
        bus1.req_valid = 1'b0;
        #1;
        chk("t1_fpu_x", x1, 32'h3F80_4000);
        chk("t1_fpu_fmt", fmt1, FP16);
        chk("t1_busy", busy1, 1);
        chk("t1_valid_c1", bus1.rsp_valid, 0);
        tick();
        chk("t1_valid_c2", bus1.rsp_valid, 0);
        tick();
        chk("t1_valid_c3", bus1.rsp_valid, 1);
        chk("t1_rsp_r", bus1.rsp_r, 32'h4000_4080);
        tick();
        chk("t1_hold_valid", bus1.rsp_valid, 1);
        chk("t1_hold_r", bus1.rsp_r, 32'h4000_4080);
        bus1.rsp_ready = 1'b1;
        tick();
        chk("t1_popped", bus1.rsp_valid, 0);
        chk("t1_idle", busy1, 0);

        // backpressure
        bus1.rsp_ready = 1'b0;
        acc = 0;
        j = 0;
        for (int c = 0; c < 6; c++) begin
            bus1.req_valid = 1'b1;
            bus1.req_x = {bfn[j+1], bfn[j+1]};
            bus1.req_y = 32'h3F80_3F80;
            #1;
            if (bus1.req_ready) begin
                acc++;
                j++;
            end
            tick();
        end
        bus1.req_valid = 1'b0;
        #1;
        chk("t2_accepted", acc, 4);
        chk("t2_full_ready", bus1.req_ready, 0);
        bus1.rsp_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 12; c++) begin
            if (bus1.rsp_valid) begin
                chk("t2_rsp_r", bus1.rsp_r, {bfn[got+2], bfn[got+2]});
                got++;
            end
            tick();
        end
        chk("t2_count", got, 4);
        chk("t2_ready_back", bus1.req_ready, 1);

        // streaming
        got = 0;
        first_c = -1;
        last_c = -1;
        for (int c = 0; c < 14; c++) begin
            bus1.req_valid = (c < 8);
            bus1.req_x = {bfn[(c % 8) + 1], bfn[(c % 8) + 1]};
            #1;
            if (c < 8) chk("t3_ready", bus1.req_ready, 1);
            if (bus1.rsp_valid) begin
                chk("t3_rsp_r", bus1.rsp_r, {bfn[(got % 8) + 2], bfn[(got % 8) + 2]});
                if (got == 0) first_c = c;
                last_c = c;
                got++;
            end
            tick();
        end
        bus1.req_valid = 1'b0;
        chk("t3_count", got, 8);
        chk("t3_no_bubbles", last_c - first_c, 7);

        // reset with two ops in flight and one buffered
        bus1.rsp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            bus1.req_valid = 1'b1;
            bus1.req_x = {bfn[c+1], bfn[c+1]};
            #1;
            chk("t4_ready", bus1.req_ready, 1);
            tick();
        end
        bus1.req_valid = 1'b0;
        #1;
        chk("t4_pre_valid", bus1.rsp_valid, 1);
        chk("t4_pre_busy", busy1, 1);
        rst = 1'b1;
        tick();
        chk("t4_rst_valid", bus1.rsp_valid, 0);
        chk("t4_rst_busy", busy1, 0);
        chk("t4_rst_ready", bus1.req_ready, 0);
        rst = 1'b0;
        bus1.rsp_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("t4_no_stale", bus1.rsp_valid, 0);
            chk("t4_no_busy", busy1, 0);
        end

        // II = 2
        pops = 0;
        for (int c = 0; c < 10; c++) begin
            bus2.req_valid = (c < 6);
            bus2.req_x = {bfn[1], bfn[1]};
            #1;
            if (c < 6) chk("t5_ready_pattern", bus2.req_ready, (c % 2 == 0) ? 1 : 0);
            if (bus2.rsp_valid) begin
                chk("t5_rsp_r", bus2.rsp_r, {bfn[2], bfn[2]});
                pops++;
            end
            tick();
        end
        chk("t5_results", pops, 3);
        chk("t5_idle", busy2, 0);

`ifdef FPALL_ISSUE_TAG_EN
        j = 0;
        got = 0;
        for (int c = 0; c < 80; c++) begin
            if (got == 4) break;
            bus1.req_valid = (j < 4);
            bus1.req_tag = tags[j % 4];
            bus1.req_x = {bfn[(j % 4) + 1], bfn[(j % 4) + 1]};
            bus1.rsp_ready = 1'($urandom_range(0, 1));
            #1;
            if (bus1.rsp_valid && bus1.rsp_ready) begin
                chk("t6_rsp_tag", bus1.rsp_tag, tags[got]);
                chk("t6_rsp_r", bus1.rsp_r, {bfn[got+2], bfn[got+2]});
                got++;
            end
            if (bus1.req_valid && bus1.req_ready) j++;
            tick();
        end
        bus1.req_valid = 1'b0;
        chk("t6_count", got, 4);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
